// File: rtl/cipher_pkg.sv
// Shared letter-arithmetic definitions for the cipher machine datapaths.
// 5-bit letters a=0..z=25; code 31 marks an invalid letter on output.
package cipher_pkg;

  localparam int CHAR_W     = 5;
  localparam int ALPHA_SIZE = 26;
  localparam logic [CHAR_W-1:0] CHAR_INVALID = 5'd31;

  // (a - b) mod ALPHA_SIZE for in-range letters, via a 6-bit intermediate sum
  function automatic logic [CHAR_W-1:0] mod_sub(input logic [CHAR_W-1:0] a,
                                                input logic [CHAR_W-1:0] b);
    logic [CHAR_W:0] s;
    if (a >= b)
      s = {1'b0, a} - {1'b0, b};
    else
      s = {1'b0, a} + (CHAR_W+1)'(ALPHA_SIZE) - {1'b0, b};
    mod_sub = CHAR_W'(s);
  endfunction

endpackage

// File: rtl/mod26_sub.sv
// Combinational letter subtractor: diff = (a - b) mod alphabet, a_ok flags a in range.
// No state, no handshake; the encoder variant feeds it a negated key.
module mod26_sub
  import cipher_pkg::*;
#(
  parameter int ALPHA = ALPHA_SIZE
) (
  input  logic [CHAR_W-1:0] a,
  input  logic [CHAR_W-1:0] b,
  output logic [CHAR_W-1:0] diff,
  output logic              a_ok
);

  assign diff = mod_sub(a, b);
  assign a_ok = a < CHAR_W'(ALPHA);

endmodule

// File: rtl/vigenere_decoder.sv
// Streaming Vigenere decoder with a serially loaded key; one output register, latency 1.
// in_ready drops with no key, during key_clear, or while the held output is stalled.
module vigenere_decoder
  import cipher_pkg::*;
#(
  parameter int KEY_MAX = 8,
  parameter int ALPHA   = ALPHA_SIZE
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         key_clear,
  input  logic                         key_wr,
  input  logic [CHAR_W-1:0]            key_char,
  input  logic                         msg_start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHAR_W-1:0]            in_char,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHAR_W-1:0]            out_char,
  output logic [$clog2(KEY_MAX+1)-1:0] key_len,
  output logic                         key_ovf,
  output logic                         bad_char
);

  localparam int KL_W  = $clog2(KEY_MAX+1);
  localparam int IDX_W = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int DEPTH = 1 << IDX_W;

  logic [CHAR_W-1:0] key_buf [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [CHAR_W-1:0] dec_char;
  logic              in_ok;
  logic              key_ok;
  logic              has_key;
  logic              key_full;
  logic              in_xfer;
  logic              key_wr_ok;
  logic              idx_wrap;

  // NOKEY/RUN is simply key_len==0 vs key_len>0
  assign has_key   = key_len != '0;
  assign key_full  = key_len == KL_W'(KEY_MAX);
  assign key_ok    = key_char < CHAR_W'(ALPHA);
  assign in_ready  = has_key & ~key_clear & (~out_valid | out_ready);
  assign in_xfer   = in_valid & in_ready;
  assign key_wr_ok = key_wr & ~key_clear & ~key_full & key_ok;
  assign idx_wrap  = KL_W'(idx) == key_len - KL_W'(1);

  mod26_sub #(.ALPHA(ALPHA)) u_sub (
    .a    (in_char),
    .b    (key_buf[idx]),
    .diff (dec_char),
    .a_ok (in_ok)
  );

  always_ff @(posedge clk) begin
    if (key_wr_ok)
      key_buf[key_len[IDX_W-1:0]] <= key_char;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_len   <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      key_ovf   <= 1'b0;
      bad_char  <= 1'b0;
    end else begin
      if (key_clear) begin
        key_len  <= '0;
        idx      <= '0;
        key_ovf  <= 1'b0;
        bad_char <= 1'b0;
      end else begin
        if (key_wr_ok)
          key_len <= key_len + KL_W'(1);
        if (key_wr & key_full)
          key_ovf <= 1'b1;
        if ((key_wr & ~key_ok) | (in_xfer & ~in_ok))
          bad_char <= 1'b1;
        // a letter accepted alongside msg_start still used the old idx
        if (msg_start)
          idx <= '0;
        else if (in_xfer & in_ok)
          idx <= idx_wrap ? '0 : idx + IDX_W'(1);
      end

      // a pending output survives key_clear and drains normally
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_char  <= in_ok ? dec_char : CHAR_INVALID;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vigenere_decoder.sv
// Bench for vigenere_decoder: directed cases plus random traffic against a queue-based model.
module tb_vigenere_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_clear, key_wr, msg_start, in_valid, out_ready;
  logic [4:0] key_char, in_char;
  logic       in_ready, out_valid, key_ovf, bad_char;
  logic [4:0] out_char;
  logic [3:0] key_len;

  always #10 clk = ~clk;

  vigenere_decoder #(.KEY_MAX(8), .ALPHA(26)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_clear (key_clear),
    .key_wr    (key_wr),
    .key_char  (key_char),
    .msg_start (msg_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .key_len   (key_len),
    .key_ovf   (key_ovf),
    .bad_char  (bad_char)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int mkey[$];
  int midx;
  bit mv;
  int mchar;
  bit movf, mbad;
  int obs[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mkey.delete();
    midx  = 0;
    mv    = 0;
    mchar = 0;
    movf  = 0;
    mbad  = 0;
  endtask

  // called just after a falling edge with inputs applied; ends on the next falling edge
  task automatic tick(output bit acc);
    bit rdy, ox;
    #1;
    rdy = (mkey.size() != 0) && !key_clear && (!mv || out_ready);
    check("in_ready",  in_ready,  rdy);
    check("out_valid", out_valid, mv);
    check("out_char",  out_char,  mchar);
    check("key_len",   key_len,   mkey.size());
    check("key_ovf",   key_ovf,   movf);
    check("bad_char",  bad_char,  mbad);
    acc = in_valid && rdy;
    ox  = mv && out_ready;
    if (out_valid && out_ready) obs.push_back(out_char);
    if (acc) begin
      mv = 1;
      if (in_char >= 26) begin
        mchar = 31;
        mbad  = 1;
      end else begin
        mchar = (int'(in_char) - mkey[midx] + 26) % 26;
        midx  = (midx + 1) % mkey.size();
      end
    end else if (ox) begin
      mv = 0;
    end
    if (key_clear) begin
      mkey.delete();
      midx = 0;
      movf = 0;
      mbad = 0;
    end else begin
      if (key_wr) begin
        if (mkey.size() >= 8) movf = 1;
        if (key_char >= 26) mbad = 1;
        if (mkey.size() < 8 && key_char < 26) mkey.push_back(int'(key_char));
      end
      if (msg_start) midx = 0;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit kc, input bit kw, input int kch, input bit ms,
                     input bit iv, input int ich, input bit ordy, output bit acc);
    key_clear = kc;
    key_wr    = kw;
    key_char  = 5'(kch);
    msg_start = ms;
    in_valid  = iv;
    in_char   = 5'(ich);
    out_ready = ordy;
    tick(acc);
    key_clear = 0;
    key_wr    = 0;
    msg_start = 0;
    in_valid  = 0;
  endtask

  task automatic load_key(input int k[$]);
    bit a;
    cyc(1, 0, 0, 0, 0, 0, 1, a);
    foreach (k[i]) cyc(0, 1, k[i], 0, 0, 0, 1, a);
  endtask

  // send letters, holding each until accepted; out_ready low for cycles [stall_at, stall_at+stall_len)
  task automatic feed(input int s[$], input int stall_at, input int stall_len);
    bit a;
    bit ordy;
    int i = 0;
    int n = 0;
    while (i < s.size() && n < 200) begin
      ordy = !(n >= stall_at && n < stall_at + stall_len);
      cyc(0, 0, 0, 0, 1, s[i], ordy, a);
      if (a) i++;
      n++;
    end
    if (i < s.size()) check("feed_timeout", i, s.size());
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, a);
  endtask

  task automatic check_obs(input string tag, input int e[$]);
    check({tag, "_count"}, obs.size(), e.size());
    for (int i = 0; i < e.size() && i < obs.size(); i++)
      check(tag, obs[i], e[i]);
    obs.delete();
  endtask

  int lemon[$]  = '{11, 4, 12, 14, 13};
  int lxfopv[$] = '{11, 23, 5, 14, 15, 21};
  int attack[$] = '{0, 19, 19, 0, 2, 10};
  int nine[$]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int key_b[$]  = '{1};
  int t4_in[$]  = '{0, 31, 1};
  int t4_out[$] = '{25, 31, 0};
  int two[$]    = '{11, 23};
  int one[$]    = '{11};
  int t5_out[$] = '{0, 19, 0, 7, 0};
  int abc[$]    = '{1, 2, 3};
  int rkey[$];

  initial begin
    bit a;
    resetn    = 0;
    key_clear = 0;
    key_wr    = 0;
    key_char  = 0;
    msg_start = 0;
    in_valid  = 0;
    in_char   = 0;
    out_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_char",  out_char,  0);
    check("rst_key_len",   key_len,   0);
    check("rst_key_ovf",   key_ovf,   0);
    check("rst_bad_char",  bad_char,  0);
    resetn = 1;

    // 1: LEMON / LXFOPV -> ATTACK, free-flowing
    load_key(lemon);
    feed(lxfopv, 1000, 0);
    check_obs("t1_attack", attack);

    // 2: same stream with a 3-cycle downstream stall
    load_key(lemon);
    feed(lxfopv, 3, 3);
    check_obs("t2_stall", attack);

    // 3: overflow then clear
    load_key(nine);
    check("t3_len", key_len, 8);
    check("t3_ovf", key_ovf, 1);
    cyc(1, 0, 0, 0, 1, 3, 1, a);
    cyc(0, 0, 0, 0, 1, 3, 1, a);
    check("t3_len_clr", key_len, 0);
    check("t3_ovf_clr", key_ovf, 0);
    check("t3_rdy_clr", in_ready, 0);

    // 4: wrap-around and invalid letter
    load_key(key_b);
    feed(t4_in, 1000, 0);
    check_obs("t4_wrap", t4_out);
    check("t4_bad", bad_char, 1);

    // 5: msg_start alone, then together with an accepted letter
    load_key(lemon);
    obs.delete();
    feed(two, 1000, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, a);
    feed(one, 1000, 0);
    cyc(0, 0, 0, 1, 1, 11, 1, a);
    feed(one, 1000, 0);
    check_obs("t5_resync", t5_out);

    // 6: asynchronous reset with an output pending
    load_key(abc);
    cyc(0, 0, 0, 0, 1, 5, 0, a);
    check("t6_pending", out_valid, 1);
    #3 resetn = 0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_char",  out_char,  0);
    check("t6_async_len",   key_len,   0);
    model_reset();
    obs.delete();
    @(negedge clk);
    resetn = 1;
    cyc(0, 0, 0, 0, 1, 3, 1, a);

    // random traffic
    rkey.delete();
    for (int i = 0; i < 4; i++) rkey.push_back($urandom_range(0, 25));
    load_key(rkey);
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 19) == 0,
          ($urandom_range(0, 15) == 0) ? 27 : $urandom_range(0, 25),
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 7,
          ($urandom_range(0, 19) == 0) ? 30 : $urandom_range(0, 25),
          $urandom_range(0, 9) < 7,
          a);
    end
    obs.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
